md_iter_unit: RTL
=================

// Module: md_iter_unit
// PURPOSE
//  Parametrised iterative multiply/divide unit with architectural HI/LO registers.
//  Sits beside the ALU in the EX stage.
//  Successor to the single-cycle MD processor. Adds:
//   - configurable width;
//   - a radix-2 multi-cycle datapath;
//   - a start/busy/done handshake for pipeline stalling;
//   - flush abort;
//   - MTHI/MTLO writes.
//  The EX stage stalls any HI/LO reader (MFHI/MFLO, or a new MD op) while busy=1.
// PARAMETERS
//  XLEN        32  operand, HI and LO width (>=4, even)
//  FAST_DIV0   1   1: divide-by-zero resolves without iterating; 0: iterate like any divide
// PORTS
//  clk    in   1     rising-edge clock
//  rst    in   1     synchronous reset, active-high
//  flush  in   1     EX flush; aborts the current operation
//  start  in   1     op valid this cycle (only sampled when busy=0)
//  op     in   3     000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x NOP
//  a      in   XLEN  forwarded rs value (multiplicand/dividend; MTHI/MTLO source)
//  b      in   XLEN  forwarded rt value (multiplier/divisor)
//  busy   out  1     operation in flight; HI/LO not yet valid
//  done   out  1     one-cycle pulse; new HI/LO visible this cycle
//  hi     out  XLEN  HI register (remainder / upper product)
//  lo     out  XLEN  LO register (quotient / lower product)
// BEHAVIOUR
//  Reset: hi=0, lo=0, busy=0, done=0, FSM=IDLE, iteration counter=0.
//   rst overrides flush and start, including mid-operation.
//  FSM states: IDLE, MUL, DIV, FIX. busy = (state != IDLE).
//  IDLE, start=1, flush=0:
//   - MULT/MULTU: latch |a|, |b| and result sign. Enter MUL with cnt=0.
//   - DIV/DIVU, b!=0: latch |a|, |b| and result sign. Enter DIV with cnt=0.
//   - DIV/DIVU, b==0, FAST_DIV0=1: go directly to FIX.
//   - MTHI: hi<=a at this edge. MTLO: lo<=a. State stays IDLE, done stays 0.
//   - NOP: ignored.
//  Signedness: MULT/DIV take magnitudes of two's-complement inputs.
//   MULTU/DIVU use a, b unchanged.
//  MUL: one shift-add step per cycle on a 2*XLEN accumulator; cnt++.
//   Leave to FIX after step XLEN-1.
//  DIV: one restoring step per cycle (shift, trial subtract, set quotient bit); cnt++.
//   Leave to FIX after step XLEN-1.
//  FIX (1 cycle), at its closing edge:
//   - Signed multiply with differing signs: {hi,lo} <= -product.
//   - Signed divide: quotient negated if a and b signs differ; remainder takes the sign of a.
//   - Writes {hi,lo}, state->IDLE, and done=1 for the following cycle.
//  Latency: start accepted at edge E0. MUL/DIV steps at edges E1..E(XLEN). FIX closes at E(XLEN+1).
//   done=1 and new hi/lo are visible in the cycle after E(XLEN+1).
//   busy=1 from after E0 through E(XLEN+1).
//  Divide by zero, either FAST_DIV0 value: hi<=a, lo<=all-ones.
//   FAST_DIV0=1: FIX straight after E0, so done follows E1.
//   FAST_DIV0=0: the divide runs its full latency; the FIX result is still forced to hi=a, lo=all-ones.
//  Signed overflow, DIV of most-negative by -1: lo<=most-negative, hi<=0. No trap.
//  Arithmetic: all intermediates are at least XLEN+1 bits, so no carry is lost.
//   Negation is two's complement, modulo 2^XLEN (hi/lo) or 2^(2*XLEN) (product).
//  Boundary and priority rules:
//   - start while busy=1: ignored; the operation is not queued. EX must hold it via stall.
//   - flush with busy=1: state->IDLE at that edge, hi/lo unchanged, no done pulse.
//   - flush in IDLE together with start: start ignored, including MTHI/MTLO.
//   - flush in the FIX cycle: the write is suppressed, done stays 0.
//   - done is never asserted in two consecutive cycles.
//     A new start is accepted in the done cycle (busy=0).
// TESTING
//  1 MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
//    done exactly 34 cycles after the start edge.
//  2 MULT a=-3 b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
//    DIV a=-7 b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//  3 DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0.
//    DIVU a=5 b=0 with FAST_DIV0=1 -> hi=5, lo=0xFFFFFFFF, done at 2 cycles.
//  4 Start MULT, assert flush at cycle 10 -> busy=0 next cycle, hi/lo keep old values, no done.
//    Reapplying start with a second op while busy -> that op is ignored.
//  5 MTHI a=0x1234 then MTLO a=0x5678 on back-to-back cycles -> hi=0x1234, lo=0x5678.
//    busy and done stay 0 throughout.
//  6 rst mid-DIV -> hi=lo=0, busy=0 next cycle.
//    Repeat test 1 at XLEN=16: 0xFFFF*0xFFFF -> hi=0xFFFE, lo=0x0001, done after 18 cycles.

Source files
------------

// File: rtl/md_iter_unit.sv
`default_nettype none
// ============================================================================
//  Module      : md_iter_unit
//  Description : Radix-2 iterative multiply/divide unit holding the HI/LO
//                registers, with a start/busy/done handshake and flush abort.
//  Revision    : 1.0 - initial release
// ============================================================================
module md_iter_unit #(
  parameter int XLEN      = 32,
  parameter bit FAST_DIV0 = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_flush,
  input  logic            i_start,
  input  logic [2:0]      i_op,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_hi,
  output logic [XLEN-1:0] o_lo
);

  localparam int                c_cnt_w  = $clog2(XLEN);
  localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(XLEN - 1);
  localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);
  localparam logic [2:0]        c_op_mult  = 3'b000;
  localparam logic [2:0]        c_op_multu = 3'b001;
  localparam logic [2:0]        c_op_div   = 3'b010;
  localparam logic [2:0]        c_op_divu  = 3'b011;
  localparam logic [2:0]        c_op_mthi  = 3'b100;
  localparam logic [2:0]        c_op_mtlo  = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } state_t;

  state_t               r_state;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [XLEN-1:0]      r_hi;
  logic [XLEN-1:0]      r_lo;
  logic                 r_done;
  logic [2*XLEN-1:0]    r_acc;
  logic [XLEN-1:0]      r_mcand;
  logic [XLEN-1:0]      r_quo;
  logic [XLEN-1:0]      r_rem;
  logic [XLEN-1:0]      r_dvsr;
  logic [XLEN-1:0]      r_a_raw;
  logic                 r_neg_res;
  logic                 r_neg_rem;
  logic                 r_is_div;
  logic                 r_div0;

  logic                 w_signed;
  logic                 w_a_neg;
  logic                 w_b_neg;
  logic [XLEN-1:0]      w_a_mag;
  logic [XLEN-1:0]      w_b_mag;
  logic                 w_b_zero;
  logic [XLEN:0]        w_sum;
  logic [XLEN:0]        w_shift;
  logic                 w_ge;
  logic [2*XLEN-1:0]    w_prod_fix;
  logic [XLEN-1:0]      w_quo_fix;
  logic [XLEN-1:0]      w_rem_fix;

  // Signed ops work on magnitudes; the signs are reapplied in FIX.
  assign w_signed = ~i_op[0];
  assign w_a_neg  = w_signed & i_a[XLEN-1];
  assign w_b_neg  = w_signed & i_b[XLEN-1];
  assign w_a_mag  = w_a_neg ? -i_a : i_a;
  assign w_b_mag  = w_b_neg ? -i_b : i_b;
  assign w_b_zero = (i_b == '0);

  // Shift-add step: add the multiplicand into the upper half, then shift right.
  assign w_sum = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_mcand} : '0);

  // Restoring step: bring in the next dividend bit and try the subtract.
  assign w_shift = {r_rem, r_quo[XLEN-1]};
  assign w_ge    = (w_shift >= {1'b0, r_dvsr});

  assign w_prod_fix = r_neg_res ? -r_acc : r_acc;
  assign w_quo_fix  = r_neg_res ? -r_quo : r_quo;
  assign w_rem_fix  = r_neg_rem ? -r_rem : r_rem;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_done    <= 1'b0;
      r_acc     <= '0;
      r_mcand   <= '0;
      r_quo     <= '0;
      r_rem     <= '0;
      r_dvsr    <= '0;
      r_a_raw   <= '0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_is_div  <= 1'b0;
      r_div0    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_flush && (r_state != S_IDLE)) begin
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (i_start && !i_flush) begin
              case (i_op)
                c_op_mult, c_op_multu: begin
                  r_acc     <= {{XLEN{1'b0}}, w_b_mag};
                  r_mcand   <= w_a_mag;
                  r_neg_res <= w_a_neg ^ w_b_neg;
                  r_neg_rem <= 1'b0;
                  r_is_div  <= 1'b0;
                  r_div0    <= 1'b0;
                  r_cnt     <= '0;
                  r_state   <= S_MUL;
                end
                c_op_div, c_op_divu: begin
                  r_quo     <= w_a_mag;
                  r_rem     <= '0;
                  r_dvsr    <= w_b_mag;
                  r_a_raw   <= i_a;
                  r_neg_res <= w_a_neg ^ w_b_neg;
                  r_neg_rem <= w_a_neg;
                  r_is_div  <= 1'b1;
                  r_div0    <= w_b_zero;
                  r_cnt     <= '0;
                  r_state   <= (w_b_zero && FAST_DIV0) ? S_FIX : S_DIV;
                end
                c_op_mthi: r_hi <= i_a;
                c_op_mtlo: r_lo <= i_a;
                default: ;
              endcase
            end
          end
          S_MUL: begin
            r_acc <= {w_sum, r_acc[XLEN-1:1]};
            r_cnt <= r_cnt + c_one;
            if (r_cnt == c_last) r_state <= S_FIX;
          end
          S_DIV: begin
            r_rem <= w_ge ? XLEN'(w_shift - {1'b0, r_dvsr}) : w_shift[XLEN-1:0];
            r_quo <= {r_quo[XLEN-2:0], w_ge};
            r_cnt <= r_cnt + c_one;
            if (r_cnt == c_last) r_state <= S_FIX;
          end
          S_FIX: begin
            // Divide-by-zero result is forced regardless of what the iterations left.
            if (r_is_div) begin
              if (r_div0) begin
                r_hi <= r_a_raw;
                r_lo <= '1;
              end else begin
                r_hi <= w_rem_fix;
                r_lo <= w_quo_fix;
              end
            end else begin
              r_hi <= w_prod_fix[2*XLEN-1:XLEN];
              r_lo <= w_prod_fix[XLEN-1:0];
            end
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign o_busy = (r_state != S_IDLE);
  assign o_done = r_done;
  assign o_hi   = r_hi;
  assign o_lo   = r_lo;

endmodule
`default_nettype wire
